// File: rtl/iob_uart_rx_pkg.sv
// Shared types and constants for the iob_uart_rx_fc receiver.
//   state_t    : receiver FSM states
//   FRAME_BITS : start + 8 data + stop
//   MIN_DIV    : smallest usable bit-period divisor
package iob_uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned MIN_DIV    = 4;

endpackage

// File: rtl/iob_uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   push, wdata     : write request and data (accepted when not full, or full with a pop)
//   pop             : read request (ignored while empty)
//   rdata           : head entry, valid whenever empty is low
//   full, empty     : occupancy status
//   level           : number of stored entries
module iob_uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (!do_push && do_pop) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/iob_uart_rx_fc.sv
// 8N1 UART receiver with FWFT receive FIFO and RTS flow control.
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   en_i            : receiver enable; low aborts any frame and drops rts_o
//   div_i           : clock cycles per bit (values below 4 act as 4), latched at frame start
//   rxd_i           : asynchronous serial input, idle high
//   rts_o           : peer may send (one slot of margin kept for a byte in flight)
//   data_o, valid_o : FIFO head byte and non-empty flag
//   ready_i         : consumer accepts the head byte
//   level_o         : FIFO occupancy
//   frame_err_o     : sticky, stop bit sampled low
//   overrun_o       : sticky, byte dropped on full FIFO
//   clr_err_i       : clears both sticky flags (a same-cycle set wins)
module iob_uart_rx_fc
    import iob_uart_rx_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic                          en_i,
    input  logic [DIV_W-1:0]              div_i,
    input  logic                          rxd_i,
    output logic                          rts_o,
    output logic [DATA_W-1:0]             data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clr_err_i
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 3);

    logic              rx_s1;
    logic              rxs;
    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_nx;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_nx;
    logic [DIV_W-1:0]  div_eff;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_nx;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_nx;
    logic              tick;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              fe_set;
    logic              ov_set;

    assign div_eff = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
    assign tick    = (cnt == '0);
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;

    // Two-flop synchronizer; idle-high reset avoids a false start after reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rxd_i;
            rxs   <= rx_s1;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= '0;
            sh      <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_q   <= div_nx;
            sh      <= sh_nx;
            bit_idx <= bit_idx_nx;
        end
    end

    // Next-state and frame datapath.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        div_nx     = div_q;
        sh_nx      = sh;
        bit_idx_nx = bit_idx;
        push       = 1'b0;
        fe_set     = 1'b0;
        ov_set     = 1'b0;

        case (state)
            IDLE: begin
                if (en_i && !rxs) begin
                    // Half a bit period lands the start sample mid-bit.
                    div_nx   = div_eff;
                    cnt_nx   = (div_eff >> 1) - DIV_W'(1);
                    state_nx = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx     = div_q - DIV_W'(1);
                        bit_idx_nx = '0;
                        state_nx   = DATA;
                    end
                end else begin
                    cnt_nx = cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    sh_nx      = {rxs, sh[DATA_W-1:1]};
                    cnt_nx     = div_q - DIV_W'(1);
                    bit_idx_nx = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_nx = cnt - DIV_W'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxs) begin
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            ov_set = 1'b1;
                        end
                        state_nx = IDLE;
                    end else begin
                        fe_set   = 1'b1;
                        state_nx = BREAK;
                    end
                end else begin
                    cnt_nx = cnt - DIV_W'(1);
                end
            end
            BREAK: begin
                // Held-low line: wait for idle before hunting for a new start bit.
                if (rxs) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Disable aborts the frame in flight without touching FIFO or flags.
        if (!en_i) begin
            state_nx = IDLE;
            push     = 1'b0;
            fe_set   = 1'b0;
            ov_set   = 1'b0;
        end
    end

    // Sticky error flags and flow control.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            rts_o       <= 1'b0;
        end else begin
            if (fe_set) begin
                frame_err_o <= 1'b1;
            end else if (clr_err_i) begin
                frame_err_o <= 1'b0;
            end
            if (ov_set) begin
                overrun_o <= 1'b1;
            end else if (clr_err_i) begin
                overrun_o <= 1'b0;
            end
            rts_o <= en_i && (level_o < LVL_W'(FIFO_DEPTH - 1));
        end
    end

    iob_uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push     (push),
        .wdata    (sh),
        .pop      (pop),
        .rdata    (data_o),
        .full     (full),
        .empty    (empty),
        .level    (level_o)
    );

endmodule

// File: tb/tb_iob_uart_rx_fc.sv
// Self-checking bench for iob_uart_rx_fc: directed frames, scoreboard on the output handshake.
module tb_iob_uart_rx_fc;

    localparam int unsigned DIV = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        en;
    logic [15:0] div;
    logic        rxd;
    logic        rts;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [2:0]  level;
    logic        fe;
    logic        ov;
    logic        clr;

    int          total  = 0;
    int          passed = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    iob_uart_rx_fc dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .en_i        (en),
        .div_i       (div),
        .rxd_i       (rxd),
        .rts_o       (rts),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .level_o     (level),
        .frame_err_o (fe),
        .overrun_o   (ov),
        .clr_err_i   (clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted head byte must match the next expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (arst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got byte %02h, expected none", data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(data), 32'(e));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame LSB first; called and returns at posedge+1, leaves the stop level on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(DIV);
        end
        rxd = stop_bit;
        idle(DIV);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        arst_n = 1'b0;
        en     = 1'b1;
        div    = 16'(DIV);
        rxd    = 1'b1;
        ready  = 1'b1;
        clr    = 1'b0;
        idle(3);

        // Reset state
        check("rst_rts", 32'(rts), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_data", 32'(data), 0);
        check("rst_fe", 32'(fe), 0);
        check("rst_ov", 32'(ov), 0);
        arst_n = 1'b1;
        idle(2);
        check("rts_after_rst", 32'(rts), 1);

        // Basic frame and latency (k = first posedge after rxd falls; push at k+154)
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 400 && lat == 0; i++) begin
                    @(posedge clk);
                    #1;
                    if (valid) lat = i;
                end
                check("latency", 32'(lat), 155);
                @(posedge clk);
                #1;
                check("valid_pulse", 32'(valid), 0);
            end
        join
        check("basic_fe", 32'(fe), 0);

        // False start
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        check("fs_valid", 32'(valid), 0);
        check("fs_fe", 32'(fe), 0);
        check("fs_ov", 32'(ov), 0);

        // Frame error then break held for 50 bit times
        send_frame(8'h3C, 1'b0);
        check("fe_set", 32'(fe), 1);
        check("fe_nopush", 32'(level), 0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("fe_clr", 32'(fe), 0);
        idle(50 * DIV);
        check("brk_no_refe", 32'(fe), 0);
        check("brk_nopush", 32'(level), 0);
        rxd = 1'b1;
        idle(20);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(5);
        check("post_brk_level", 32'(level), 0);

        // ready while empty is ignored
        idle(5);
        check("empty_ready", 32'(level), 0);

        // Flow control and overrun
        ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
            if (b == 2) check("rts_lvl2", 32'(rts), 1);
            if (b == 3) begin
                check("rts_lvl3", 32'(rts), 0);
                check("lvl3", 32'(level), 3);
            end
        end
        check("ovr_level", 32'(level), 4);
        check("ovr_flag", 32'(ov), 1);
        check("ovr_head", 32'(data), 8'h01);
        ready = 1'b1;
        idle(8);
        check("drain_level", 32'(level), 0);
        check("drain_rts", 32'(rts), 1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("ov_clr", 32'(ov), 0);

        // Simultaneous push and pop on a full FIFO
        ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b * 16));
            send_frame(8'(b * 16), 1'b1);
        end
        check("full_level", 32'(level), 4);
        exp_q.push_back(8'h5A);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(154);
                ready = 1'b1;
                idle(1);
                ready = 1'b0;
            end
        join
        check("simul_level", 32'(level), 4);
        check("simul_ov", 32'(ov), 0);
        check("simul_head", 32'(data), 8'h20);
        ready = 1'b1;
        idle(8);
        check("simul_drain", 32'(level), 0);

        // Mid-frame disable: FIFO retained, frame dropped
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'hF7, 1'b1);
            begin
                idle(4 * DIV + 8);
                en = 1'b0;
                idle(3);
                check("dis_rts", 32'(rts), 0);
                check("dis_level", 32'(level), 1);
            end
        join
        en = 1'b1;
        idle(10);
        check("dis_nopush", 32'(level), 1);
        check("dis_head", 32'(data), 8'h11);
        ready = 1'b1;
        idle(3);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        idle(5);
        check("reen_level", 32'(level), 0);

        // Asynchronous reset mid-frame
        ready = 1'b0;
        send_frame(8'h99, 1'b1);
        check("pre_rst_level", 32'(level), 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(60);
                arst_n = 1'b0;
                #1;
                check("mrst_rts", 32'(rts), 0);
                check("mrst_valid", 32'(valid), 0);
                check("mrst_level", 32'(level), 0);
                check("mrst_data", 32'(data), 0);
                check("mrst_fe", 32'(fe), 0);
                check("mrst_ov", 32'(ov), 0);
                idle(2);
                arst_n = 1'b1;
                #1;
                check("mrst_rts_rel", 32'(rts), 0);
                idle(1);
                check("mrst_rts_up", 32'(rts), 1);
            end
        join
        idle(20);
        check("mrst_nopush", 32'(level), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
